bcd_multi_converter: RTL and testbench

- Sequential, parametrised successor to the combinational unit/tens splitter that feeds the display path.
- Converts CHANNELS unsigned binary values of WIDTH bits into DIGITS packed BCD digits each, using iterative shift-add-3 (double dabble), one bit per clock.
- A single conversion core is time-shared across channels.
- Sits between the datapath/keypad registers and the 7-segment digit drivers; adds a start/done handshake and overflow saturation.

---
 rtl/bcd_multi_converter_pkg.sv | 39 +++
 rtl/bcd_multi_converter_if.sv | 29 ++
 rtl/bcd_multi_converter_dabble_step.sv | 28 ++
 rtl/bcd_multi_converter.sv | 152 +++++++++++++++
 tb/tb_bcd_multi_converter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_multi_converter_pkg.sv
// Shared definitions for the multi-channel binary-to-BCD converter.
//   state_e    : converter FSM states (IDLE, CONVERT)
//   BCD_NINE   : digit value used when a channel saturates
//   clog2      : counter/index width helper
//   min_digits : BCD digits needed to hold 2^width-1 without overflow
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'h9;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int min_digits(input int width);
    longint unsigned maxv;
    int d;
    maxv = (64'd1 << width) - 64'd1;
    d = 1;
    while (maxv >= 64'd10) begin
      maxv = maxv / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_multi_converter_if.sv
// Request/result bundle between the datapath registers and the converter.
//   start    : conversion request (master -> slave)
//   data_in  : CHANNELS packed binary values, channel c at [c*WIDTH +: WIDTH]
//   busy     : conversion in progress
//   done     : one-cycle pulse, bcd_out/overflow just updated
//   bcd_out  : channel c at [c*DIGITS*4 +: DIGITS*4], units in the low nibble
//   overflow : bit c set when channel c saturated to all nines
interface bcd_multi_converter_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 2
);
  logic                         start;
  logic [CHANNELS*WIDTH-1:0]    data_in;
  logic                         busy;
  logic                         done;
  logic [CHANNELS*DIGITS*4-1:0] bcd_out;
  logic [CHANNELS-1:0]          overflow;

  modport master (
    output start, data_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, data_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bcd_multi_converter_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift
// {bcd, bin} left by one bit.
//   bcd, bin            : current accumulator and remaining binary bits
//   bcd_next, bin_next  : accumulator after adjust+shift
//   carry_out           : bit shifted out of the top digit
module bcd_dabble_step #(
  parameter int DIGITS = 2,
  parameter int WIDTH  = 4
) (
  input  logic [DIGITS*4-1:0] bcd,
  input  logic [WIDTH-1:0]    bin,
  output logic [DIGITS*4-1:0] bcd_next,
  output logic [WIDTH-1:0]    bin_next,
  output logic                carry_out
);

  logic [DIGITS*4-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
  end

  assign {carry_out, bcd_next, bin_next} = {adj, bin, 1'b0};

endmodule

// File: rtl/bcd_multi_converter.sv
// Time-shared double-dabble converter: CHANNELS binary values of WIDTH bits
// become DIGITS packed BCD digits each, one bit per clock, CHANNELS*WIDTH
// cycles per request. Channels whose value needs more than DIGITS digits
// saturate to all nines and raise their overflow bit.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : start/data_in in, busy/done/bcd_out/overflow out
module bcd_multi_converter
  import bcd_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_multi_converter_if.slave  bus
);

  localparam int CH_W  = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
  localparam int CNT_W = clog2(WIDTH + 1);
  localparam int BCD_W = DIGITS * 4;
  // When DIGITS covers 2^WIDTH-1 the top digit can never carry out.
  localparam bit OVF_POSSIBLE = (DIGITS < min_digits(WIDTH));

  state_e                     state;
  logic [CH_W-1:0]            ch_idx;
  logic [CNT_W-1:0]           bit_cnt;
  logic [CHANNELS*WIDTH-1:0]  snap;
  logic [BCD_W-1:0]           bcd_acc;
  logic [WIDTH-1:0]           bin_acc;
  logic                       ovf_acc;
  logic [CHANNELS*BCD_W-1:0]  shadow_bcd;
  logic [CHANNELS-1:0]        shadow_ovf;
  logic [CHANNELS*BCD_W-1:0]  bcd_q;
  logic [CHANNELS-1:0]        ovf_q;
  logic                       busy_q;
  logic                       done_q;

  logic [BCD_W-1:0]           step_bcd;
  logic [WIDTH-1:0]           step_bin;
  logic                       step_carry;
  logic                       chan_ovf;
  logic [BCD_W-1:0]           chan_bcd;
  logic                       last_shift;
  logic                       last_chan;
  logic [WIDTH-1:0]           next_bin;
  logic [CHANNELS*BCD_W-1:0]  shadow_bcd_nxt;
  logic [CHANNELS-1:0]        shadow_ovf_nxt;

  bcd_dabble_step #(
    .DIGITS (DIGITS),
    .WIDTH  (WIDTH)
  ) u_step (
    .bcd       (bcd_acc),
    .bin       (bin_acc),
    .bcd_next  (step_bcd),
    .bin_next  (step_bin),
    .carry_out (step_carry)
  );

  assign last_shift = (bit_cnt == CNT_W'(1));
  assign last_chan  = (ch_idx == CH_W'(CHANNELS - 1));
  assign chan_ovf   = OVF_POSSIBLE & (ovf_acc | step_carry);
  assign chan_bcd   = chan_ovf ? {DIGITS{BCD_NINE}} : step_bcd;

  // Binary operand of the following channel, taken from the snapshot.
  always_comb begin
    next_bin = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (CH_W'(c) == ch_idx + 1'b1) next_bin = snap[c*WIDTH +: WIDTH];
    end
  end

  // Shadow contents including the channel finishing this cycle, so the last
  // channel lands in the outputs on the same edge as all the others.
  always_comb begin
    shadow_bcd_nxt = shadow_bcd;
    shadow_ovf_nxt = shadow_ovf;
    for (int c = 0; c < CHANNELS; c++) begin
      if (CH_W'(c) == ch_idx) begin
        shadow_bcd_nxt[c*BCD_W +: BCD_W] = chan_bcd;
        shadow_ovf_nxt[c]                = chan_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch_idx     <= '0;
      bit_cnt    <= '0;
      snap       <= '0;
      bcd_acc    <= '0;
      bin_acc    <= '0;
      ovf_acc    <= 1'b0;
      shadow_bcd <= '0;
      shadow_ovf <= '0;
      bcd_q      <= '0;
      ovf_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= CONVERT;
            busy_q  <= 1'b1;
            snap    <= bus.data_in;
            ch_idx  <= '0;
            bit_cnt <= CNT_W'(WIDTH);
            bcd_acc <= '0;
            bin_acc <= bus.data_in[WIDTH-1:0];
            ovf_acc <= 1'b0;
          end
        end
        CONVERT: begin
          if (last_shift) begin
            shadow_bcd <= shadow_bcd_nxt;
            shadow_ovf <= shadow_ovf_nxt;
            bcd_acc    <= '0;
            ovf_acc    <= 1'b0;
            bit_cnt    <= CNT_W'(WIDTH);
            bin_acc    <= next_bin;
            if (last_chan) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              bcd_q  <= shadow_bcd_nxt;
              ovf_q  <= shadow_ovf_nxt;
            end else begin
              ch_idx <= ch_idx + 1'b1;
            end
          end else begin
            bcd_acc <= step_bcd;
            bin_acc <= step_bin;
            ovf_acc <= ovf_acc | step_carry;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bcd_multi_converter.sv
// Bench for bcd_multi_converter: four instances in different shapes
// (3x4b/2d, 1x8b/2d, 2x8b/3d, 4x1b/1d) share one clock and reset. A per
// instance scoreboard gets an expected result when the bench model sees a
// request accepted, and is popped when done pulses.
`timescale 1ns/1ps
module tb_bcd_multi_converter;
  import bcd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] bcd;
    logic [7:0]  ovf;
    int          due;
  } exp_t;

  exp_t        sb [4][$];
  logic [63:0] held_bcd [4];
  logic [7:0]  held_ovf [4];

  bcd_multi_converter_if #(.CHANNELS(3), .WIDTH(4), .DIGITS(2)) ifa ();
  bcd_multi_converter_if #(.CHANNELS(1), .WIDTH(8), .DIGITS(2)) ifb ();
  bcd_multi_converter_if #(.CHANNELS(2), .WIDTH(8), .DIGITS(3)) ifc ();
  bcd_multi_converter_if #(.CHANNELS(4), .WIDTH(1), .DIGITS(1)) ifd ();

  bcd_multi_converter #(.CHANNELS(3), .WIDTH(4), .DIGITS(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bcd_multi_converter #(.CHANNELS(1), .WIDTH(8), .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  bcd_multi_converter #(.CHANNELS(2), .WIDTH(8), .DIGITS(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
  bcd_multi_converter #(.CHANNELS(4), .WIDTH(1), .DIGITS(1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, saturation when value >= 10^d.
  function automatic void model(input int c, input int w, input int d, input logic [63:0] data,
                                output logic [63:0] bcd, output logic [7:0] ovf);
    longint v;
    longint lim;
    bcd = '0;
    ovf = '0;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    for (int ch = 0; ch < c; ch++) begin
      v = longint'((data >> (ch * w)) & ((64'd1 << w) - 64'd1));
      if (v >= lim) begin
        ovf[ch] = 1'b1;
        for (int dg = 0; dg < d; dg++) bcd[(ch*d + dg)*4 +: 4] = 4'h9;
      end else begin
        for (int dg = 0; dg < d; dg++) begin
          bcd[(ch*d + dg)*4 +: 4] = 4'(v % 10);
          v = v / 10;
        end
      end
    end
  endfunction

  task automatic mon(input int id, input int c, input int w, input int d,
                     input logic start, input logic [63:0] data, input logic busy,
                     input logic done, input logic [63:0] bcd, input logic [7:0] ovf);
    exp_t e;
    logic eb;
    if (!rst_n) begin
      sb[id].delete();
      held_bcd[id] = '0;
      held_ovf[id] = '0;
      return;
    end
    eb = (sb[id].size() > 0) && (cyc < sb[id][0].due);
    chk($sformatf("busy%0d", id), 64'(busy), 64'(eb));
    if (done) begin
      if (sb[id].size() == 0) begin
        chk($sformatf("unexpected_done%0d", id), 64'(done), 64'd0);
      end else begin
        e = sb[id].pop_front();
        chk($sformatf("latency%0d", id), 64'(cyc), 64'(e.due));
        chk($sformatf("bcd%0d", id), bcd, e.bcd);
        chk($sformatf("ovf%0d", id), 64'(ovf), 64'(e.ovf));
        held_bcd[id] = e.bcd;
        held_ovf[id] = e.ovf;
      end
    end else begin
      if (sb[id].size() > 0 && cyc > sb[id][0].due) begin
        chk($sformatf("done_missing%0d", id), 64'(done), 64'd1);
        void'(sb[id].pop_front());
      end
      chk($sformatf("hold_bcd%0d", id), bcd, held_bcd[id]);
      chk($sformatf("hold_ovf%0d", id), 64'(ovf), 64'(held_ovf[id]));
    end
    if (start && !eb) begin
      model(c, w, d, data, e.bcd, e.ovf);
      e.due = cyc + 1 + c * w;
      sb[id].push_back(e);
    end
  endtask

  always @(negedge clk) mon(0, 3, 4, 2, ifa.start, 64'(ifa.data_in), ifa.busy, ifa.done, 64'(ifa.bcd_out), 8'(ifa.overflow));
  always @(negedge clk) mon(1, 1, 8, 2, ifb.start, 64'(ifb.data_in), ifb.busy, ifb.done, 64'(ifb.bcd_out), 8'(ifb.overflow));
  always @(negedge clk) mon(2, 2, 8, 3, ifc.start, 64'(ifc.data_in), ifc.busy, ifc.done, 64'(ifc.bcd_out), 8'(ifc.overflow));
  always @(negedge clk) mon(3, 4, 1, 1, ifd.start, 64'(ifd.data_in), ifd.busy, ifd.done, 64'(ifd.bcd_out), 8'(ifd.overflow));

  task automatic drive(input int id, input logic s, input logic [63:0] d);
    case (id)
      0: begin ifa.start = s; ifa.data_in = d[11:0]; end
      1: begin ifb.start = s; ifb.data_in = d[7:0];  end
      2: begin ifc.start = s; ifc.data_in = d[15:0]; end
      3: begin ifd.start = s; ifd.data_in = d[3:0];  end
      default: ;
    endcase
  endtask

  task automatic wait_done(input int id);
    int n;
    n = 0;
    while (sb[id].size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb[id].size() > 0) begin
      chk($sformatf("timeout%0d", id), 64'(sb[id].size()), 64'd0);
      sb[id].delete();
    end
  endtask

  task automatic run(input int id, input logic [63:0] d);
    @(posedge clk); #1;
    drive(id, 1'b1, d);
    @(posedge clk); #1;
    drive(id, 1'b0, d);
    wait_done(id);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy_a"}, 64'(ifa.busy), 64'd0);
    chk({tag, "_done_a"}, 64'(ifa.done), 64'd0);
    chk({tag, "_bcd_a"},  64'(ifa.bcd_out), 64'd0);
    chk({tag, "_ovf_a"},  64'(ifa.overflow), 64'd0);
    chk({tag, "_bcd_b"},  64'(ifb.bcd_out), 64'd0);
    chk({tag, "_ovf_b"},  64'(ifb.overflow), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      drive(i, 1'b0, 64'd0);
      held_bcd[i] = '0;
      held_ovf[i] = '0;
    end
    #1 rst_n = 1'b0;
    #1 chk_cleared("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic three-channel case: ch2..ch0 = 0, 9, 15
    run(0, 64'h09F);
    run(0, {52'd0, 4'd7, 4'd12, 4'd3});

    // Single channel with saturation boundary
    run(1, 64'd99);
    run(1, 64'd100);
    run(1, 64'd200);
    run(1, 64'd255);
    run(1, 64'd0);

    // Two channels, three digits, then a full sweep of ch0
    run(2, {48'd0, 8'd0, 8'd255});
    for (int v = 0; v < 256; v++) run(2, {48'd0, 8'($urandom_range(0, 255)), 8'(v)});

    // One-bit channels
    run(3, 64'b1010);
    run(3, 64'b0101);
    run(3, 64'b1111);

    // Start while busy is ignored; data_in changes after accept are ignored
    @(posedge clk); #1 drive(0, 1'b1, 64'h4C8);
    @(posedge clk); #1 drive(0, 1'b0, 64'hFFF);
    @(posedge clk);
    @(posedge clk); #1 drive(0, 1'b1, 64'h123);
    @(posedge clk); #1 drive(0, 1'b0, 64'h777);
    wait_done(0);

    // Start held high: continuous restarts with fresh data each cycle
    @(posedge clk); #1 drive(0, 1'b1, 64'h5E2);
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1 drive(0, 1'b1, 64'($urandom_range(0, 4095)));
    end
    drive(0, 1'b0, 64'd0);
    wait_done(0);

    // Asynchronous reset in the middle of a conversion
    @(posedge clk); #1 drive(0, 1'b1, 64'hA5B);
    @(posedge clk); #1 drive(0, 1'b0, 64'd0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_cleared("async_rst");
    #10;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    run(0, 64'h5A3);
    run(1, 64'd150);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
